// File: rtl/bus_timer.sv
// bus_timer: bus-mapped 16-bit down-counter with 8-bit prescaler, auto-reload, sticky flags and level interrupt
module bus_timer #(
  parameter logic [15:0] BASE = 16'hFF00
) (
  input  logic        CLK,
  input  logic        RST,
  inout  logic [7:0]  D,
  input  logic [15:0] A,
  input  logic        RW,
  input  logic        STB,
  output logic        INT
);
  logic sel, wr, rd, ctrl_wr, stat_wr, load, tick, uf;
  logic [2:0] off;
  logic [7:0] rdata;
  logic en_q, en_d, auto_q, auto_d, ie_q, ie_d, zf_q, zf_d, ovr_q, ovr_d, int_q;
  logic [7:0] pre_q, pre_d, rld_l_q, rld_l_d, rld_h_q, rld_h_d, snap_q, snap_d, psc_q, psc_d;
  logic [15:0] cnt_q, cnt_d;
  assign sel = STB && A[15:3] == BASE[15:3];
  assign off = A[2:0];
  assign wr = sel && !RW;
  assign rd = sel && RW && !RST;
  assign ctrl_wr = wr && off == 3'd0;
  assign stat_wr = wr && off == 3'd6;
  assign load = ctrl_wr && D[3];
  assign tick = en_q && psc_q == pre_q;
  assign uf = tick && cnt_q == 16'd0;
  assign INT = int_q;
  assign D = rd ? rdata : 8'bz;
  // register read mux; LOAD, unused bits and offset 7 read as zero
  always_comb begin
    rdata = 8'h00;
    case (off)
      3'd0: rdata = {5'd0, ie_q, auto_q, en_q};
      3'd1: rdata = pre_q;
      3'd2: rdata = rld_l_q;
      3'd3: rdata = rld_h_q;
      3'd4: rdata = cnt_q[7:0];
      3'd5: rdata = snap_q;
      3'd6: rdata = {6'd0, ovr_q, zf_q};
      default: rdata = 8'h00;
    endcase
  end
  // next state: tick acts on pre-write values, then bus writes override, flag sets beat clears
  always_comb begin
    en_d = ctrl_wr ? D[0] : en_q && !(uf && !auto_q);
    auto_d = ctrl_wr ? D[1] : auto_q;
    ie_d = ctrl_wr ? D[2] : ie_q;
    pre_d = wr && off == 3'd1 ? D : pre_q;
    rld_l_d = wr && off == 3'd2 ? D : rld_l_q;
    rld_h_d = wr && off == 3'd3 ? D : rld_h_q;
    snap_d = rd && off == 3'd4 ? cnt_q[15:8] : snap_q;
    psc_d = load || (ctrl_wr && D[0] && !en_q) ? 8'd0 : !en_q ? psc_q : tick ? 8'd0 : psc_q + 8'd1;
    cnt_d = load ? {rld_h_q, rld_l_q} : !tick ? cnt_q : cnt_q != 16'd0 ? cnt_q - 16'd1 :
            auto_q ? {rld_h_q, rld_l_q} : 16'd0;
    zf_d = uf || (zf_q && !(stat_wr && D[0]));
    ovr_d = (uf && zf_q) || (ovr_q && !(stat_wr && D[1]));
  end
  // state registers with synchronous reset overriding bus writes and ticks
  always_ff @(posedge CLK) begin
    if (RST) begin
      en_q <= 1'b0;
      auto_q <= 1'b0;
      ie_q <= 1'b0;
      pre_q <= 8'd0;
      rld_l_q <= 8'd0;
      rld_h_q <= 8'd0;
      snap_q <= 8'd0;
      psc_q <= 8'd0;
      cnt_q <= 16'd0;
      zf_q <= 1'b0;
      ovr_q <= 1'b0;
      int_q <= 1'b0;
    end else begin
      en_q <= en_d;
      auto_q <= auto_d;
      ie_q <= ie_d;
      pre_q <= pre_d;
      rld_l_q <= rld_l_d;
      rld_h_q <= rld_h_d;
      snap_q <= snap_d;
      psc_q <= psc_d;
      cnt_q <= cnt_d;
      zf_q <= zf_d;
      ovr_q <= ovr_d;
      int_q <= ie_q && zf_q;
    end
  end
endmodule
